// File: rtl/rv32_bus_pkg.sv
// Shared types for the RV32 bus arbiter: controller states and the request
// captured from the winning master.
package rv32_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        read;
        logic [3:0]  mask;
        logic [31:0] address;
        logic [31:0] wdata;
    } bus_req_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    localparam bus_req_t BUS_REQ_IDLE = '{
        read:    1'b0,
        mask:    4'h0,
        address: 32'h0000_0000,
        wdata:   32'h0000_0000
    };

    // A master asks for the bus with a read strobe or any write byte lane.
    function automatic logic is_request(input logic read, input logic [3:0] mask);
        return read | (|mask);
    endfunction

endpackage

// File: rtl/rv32_rr_select.sv
// Winner selection for the bus arbiter: fixed priority (lowest index) or
// round-robin starting one above the previous grant.
module rv32_rr_select #(
    parameter int  PORTS       = 2,
    parameter int  ROUND_ROBIN = 1,
    localparam int IDXW        = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDXW-1:0]  last_i,
    output logic             valid_o,
    output logic [IDXW-1:0]  idx_o
);

    logic [IDXW-1:0] idx_s;
    logic [IDXW-1:0] cand_s;

    // Scan from the lowest-priority candidate upward so the highest-priority requester is written last.
    always_comb begin
        idx_s  = '0;
        cand_s = '0;
        if (ROUND_ROBIN != 0) begin
            for (int k = PORTS; k >= 1; k--) begin
                cand_s = IDXW'((int'(last_i) + k) % PORTS);
                idx_s  = req_i[cand_s] ? cand_s : idx_s;
            end
        end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                idx_s = req_i[k] ? IDXW'(k) : idx_s;
            end
        end
    end

    assign valid_o = |req_i;
    assign idx_o   = idx_s;

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Multi-master RV32 bus arbiter: grants one master at a time, forwards its
// request to the bus, and returns a one-cycle completion (or timeout) pulse.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int  PORTS       = 2,
    parameter int  ROUND_ROBIN = 1,
    parameter int  TIMEOUT     = 255,
    localparam int IDXW        = $clog2(PORTS),
    localparam int CNTW        = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PORTS-1:0]      m_read_in,
    input  logic [PORTS-1:0][3:0] m_write_mask_in,
    input  logic [PORTS-1:0][31:0] m_address_in,
    input  logic [PORTS-1:0][31:0] m_write_value_in,
    output logic [PORTS-1:0]      m_ready_out,
    output logic [PORTS-1:0]      m_error_out,
    output logic [31:0]           m_read_value_out,
    output logic                  read_out,
    output logic [3:0]            write_mask_out,
    output logic [31:0]           address_out,
    output logic [31:0]           write_value_out,
    input  logic [31:0]           read_value_in,
    input  logic                  ready_in
);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  last_q, last_d;
    bus_req_t         req_q, req_d;
    logic [CNTW-1:0]  wait_q, wait_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [PORTS-1:0] ready_q, ready_d;
    logic [PORTS-1:0] err_q, err_d;

    logic [PORTS-1:0] req_vec_s;
    logic [PORTS-1:0] grant_onehot_s;
    logic             sel_valid_s;
    logic [IDXW-1:0]  sel_idx_s;

    // Collapse each master's read strobe and write lanes into one request bit.
    always_comb begin
        req_vec_s = '0;
        for (int i = 0; i < PORTS; i++) begin
            req_vec_s[i] = is_request(m_read_in[i], m_write_mask_in[i]);
        end
    end

    rv32_rr_select #(
        .PORTS       (PORTS),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_select (
        .req_i   (req_vec_s),
        .last_i  (last_q),
        .valid_o (sel_valid_s),
        .idx_o   (sel_idx_s)
    );

    assign grant_onehot_s = PORTS'(1'b1) << grant_q;

    // Next-state logic; the bus request register doubles as the bus output and is blanked outside BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        req_d   = req_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_s) begin
                    state_d       = ST_BUSY;
                    grant_d       = sel_idx_s;
                    req_d.read    = m_read_in[sel_idx_s];
                    req_d.mask    = m_write_mask_in[sel_idx_s];
                    req_d.address = m_address_in[sel_idx_s];
                    req_d.wdata   = m_write_value_in[sel_idx_s];
                    wait_d        = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ready_in) begin
                    rdata_d = req_q.read ? read_value_in : 32'h0000_0000;
                    ready_d = grant_onehot_s;
                    err_d   = '0;
                    req_d   = BUS_REQ_IDLE;
                    state_d = ST_RESP;
                end else if (wait_q == CNTW'(TIMEOUT)) begin
                    rdata_d = TIMEOUT_RDATA;
                    ready_d = grant_onehot_s;
                    err_d   = grant_onehot_s;
                    req_d   = BUS_REQ_IDLE;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + CNTW'(1'b1);
                end
            end
            ST_RESP: begin
                ready_d = '0;
                err_d   = '0;
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = BUS_REQ_IDLE;
                ready_d = '0;
                err_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer without a completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= '0;
            req_q   <= BUS_REQ_IDLE;
            wait_q  <= '0;
            rdata_q <= 32'h0000_0000;
            ready_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign m_ready_out      = ready_q;
    assign m_error_out      = err_q;
    assign m_read_value_out = rdata_q;
    assign read_out         = req_q.read;
    assign write_mask_out   = req_q.mask;
    assign address_out      = req_q.address;
    assign write_value_out  = req_q.wdata;

endmodule
